// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } hu_state_t;

  localparam int HU_CNT_W         = 4;
  localparam int LOAD_LAT_MAX     = 15;
  localparam int FLUSH_CYCLES_MAX = 15;

endpackage

// File: rtl/hazard_ctrl_unit_hit_detect.sv
// Load-use comparator: flags a decode source that matches a pending load destination.
// Shared with the forwarding unit, so it stays purely combinational.
module hu_hit_detect #(
  parameter int REG_AW = 2
) (
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic              ra_used,
  input  logic              rb_used,
  input  logic [REG_AW-1:0] rd,
  input  logic              mem_read,
  output logic              hit
);

  assign hit = mem_read && ((ra_used && (rd == ra)) || (rb_used && (rd == rb)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-busy freeze.
// Optional HU_PERF_CNT_EN adds saturating stall/flush event counters.
//
// state    | meaning
// IDLE     | no multi-cycle hazard in progress
// LU_STALL | holding PC and IF/ID for the remaining load latency
// BR_FLUSH | flushing the front end after a taken branch
module hazard_ctrl_unit
  import hu_pkg::*;
#(
  parameter int REG_AW       = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] if_id_ra,
  input  logic [REG_AW-1:0] if_id_rb,
  input  logic              if_id_ra_used,
  input  logic              if_id_rb_used,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              bt,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              flush,
  output logic              id_ex_bubble,
  output logic              freeze
`ifdef HU_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [HU_CNT_W-1:0] LU_RELOAD = HU_CNT_W'(LOAD_LAT - 1);
  localparam logic [HU_CNT_W-1:0] BR_RELOAD = HU_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [HU_CNT_W-1:0] CNT_ONE   = HU_CNT_W'(1);

  hu_state_t           state_q, state_d;
  logic [HU_CNT_W-1:0] cnt_q, cnt_d;
  logic                hit;

  hu_hit_detect #(.REG_AW(REG_AW)) u_hit (
    .ra       (if_id_ra),
    .rb       (if_id_rb),
    .ra_used  (if_id_ra_used),
    .rb_used  (if_id_rb_used),
    .rd       (id_ex_rd),
    .mem_read (id_ex_mem_read),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_busy) begin
      case (state_q)
        IDLE: begin
          if (bt) begin
            if (FLUSH_CYCLES > 1) begin
              state_d = BR_FLUSH;
              cnt_d   = BR_RELOAD;
            end
          end else if (hit) begin
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cnt_d   = LU_RELOAD;
            end
          end
        end
        LU_STALL: begin
          // A taken branch kills the stalled instruction, so the stall is abandoned.
          if (bt) begin
            if (FLUSH_CYCLES > 1) begin
              state_d = BR_FLUSH;
              cnt_d   = BR_RELOAD;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        BR_FLUSH: begin
          if (bt) begin
            cnt_d = BR_RELOAD;
          end else if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    flush        = 1'b0;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    if (rst) begin
      pc_en = 1'b1;
    end else if (mem_busy) begin
      freeze   = 1'b1;
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bt) begin
            flush        = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hit) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        LU_STALL: begin
          if (bt) begin
            flush        = 1'b1;
            id_ex_bubble = 1'b1;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        BR_FLUSH: begin
          flush        = 1'b1;
          id_ex_bubble = 1'b1;
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

`ifdef HU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && !freeze && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (bt && !mem_busy && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed-vector bench for hazard_ctrl_unit: one LOAD_LAT=3/FLUSH_CYCLES=2 instance
// and one single-cycle (1/1) instance driven by the same input rows.
module tb_hazard_ctrl_unit;

  localparam logic [4:0] DEF = 5'b11000;  // {pc_en, if_id_en, flush, id_ex_bubble, freeze}
  localparam logic [4:0] STL = 5'b00010;
  localparam logic [4:0] FLS = 5'b11110;
  localparam logic [4:0] FRZ = 5'b00001;

  typedef struct {
    logic       rst, bt, busy, mr;
    logic [1:0] rd, ra, rb;
    logic       rau, rbu;
    logic [4:0] ea, eb;
    logic       pchk;
    int         psa, pfa, psb, pfb;
  } row_t;

  row_t rows[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] if_id_ra = '0, if_id_rb = '0, id_ex_rd = '0;
  logic       if_id_ra_used = 1'b0, if_id_rb_used = 1'b0;
  logic       id_ex_mem_read = 1'b0, bt = 1'b0, mem_busy = 1'b0;

  logic a_pc_en, a_if_id_en, a_flush, a_bubble, a_freeze;
  logic b_pc_en, b_if_id_en, b_flush, b_bubble, b_freeze;
`ifdef HU_PERF_CNT_EN
  logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(2), .LOAD_LAT(3), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .if_id_ra(if_id_ra), .if_id_rb(if_id_rb),
    .if_id_ra_used(if_id_ra_used), .if_id_rb_used(if_id_rb_used),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .bt(bt), .mem_busy(mem_busy),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .flush(a_flush),
    .id_ex_bubble(a_bubble), .freeze(a_freeze)
`ifdef HU_PERF_CNT_EN
    , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
  );

  hazard_ctrl_unit #(.REG_AW(2), .LOAD_LAT(1), .FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_id_ra(if_id_ra), .if_id_rb(if_id_rb),
    .if_id_ra_used(if_id_ra_used), .if_id_rb_used(if_id_rb_used),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .bt(bt), .mem_busy(mem_busy),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .flush(b_flush),
    .id_ex_bubble(b_bubble), .freeze(b_freeze)
`ifdef HU_PERF_CNT_EN
    , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic add(input logic r_rst, input logic r_bt, input logic r_busy, input logic r_mr,
                     input logic [1:0] r_rd, input logic [1:0] r_ra, input logic r_rau,
                     input logic [1:0] r_rb, input logic r_rbu,
                     input logic [4:0] r_ea, input logic [4:0] r_eb);
    row_t r;
    r.rst = r_rst; r.bt = r_bt; r.busy = r_busy; r.mr = r_mr;
    r.rd = r_rd; r.ra = r_ra; r.rau = r_rau; r.rb = r_rb; r.rbu = r_rbu;
    r.ea = r_ea; r.eb = r_eb;
    r.pchk = 1'b0; r.psa = 0; r.pfa = 0; r.psb = 0; r.pfb = 0;
    rows.push_back(r);
  endtask

  task automatic zero(input logic [4:0] ea, input logic [4:0] eb);
    add(0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, ea, eb);
  endtask

  // load r1 in EX, decode reads r1 via ra
  task automatic hit_a(input logic r_bt, input logic r_busy, input logic [4:0] ea, input logic [4:0] eb);
    add(0, r_bt, r_busy, 1, 2'd1, 2'd1, 1, 2'd0, 0, ea, eb);
  endtask

  task automatic perf(input int sa, input int fa, input int sb, input int fb);
    rows[rows.size()-1].pchk = 1'b1;
    rows[rows.size()-1].psa = sa; rows[rows.size()-1].pfa = fa;
    rows[rows.size()-1].psb = sb; rows[rows.size()-1].pfb = fb;
  endtask

  initial begin
    add(1, 1, 0, 1, 2'd1, 2'd1, 1, 2'd0, 0, DEF, DEF);        // 0  reset forces defaults
    zero(DEF, DEF);                                           // 1
    add(0, 0, 0, 1, 2'd1, 2'd1, 0, 2'd1, 0, DEF, DEF);        // 2  match but sources unused
    add(0, 0, 0, 1, 2'd2, 2'd0, 1, 2'd2, 1, STL, STL);        // 3  rb hit
    zero(STL, DEF);                                           // 4
    zero(STL, DEF);                                           // 5  last of 3 stall cycles
    zero(DEF, DEF);                                           // 6
    hit_a(0, 0, STL, STL);                                    // 7
    hit_a(0, 0, STL, STL);                                    // 8
    hit_a(0, 0, STL, STL);                                    // 9
    hit_a(0, 0, STL, STL);                                    // 10 back-to-back fresh stall
    zero(STL, DEF);                                           // 11
    zero(STL, DEF);                                           // 12
    add(0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, FLS, FLS);        // 13 branch
    zero(FLS, DEF);                                           // 14
    zero(DEF, DEF);                                           // 15
    add(0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, FLS, FLS);        // 16 branch
    hit_a(1, 0, FLS, FLS);                                    // 17 second branch reloads
    hit_a(0, 0, FLS, STL);                                    // 18 hit ignored while flushing
    zero(DEF, DEF);                                           // 19
    hit_a(0, 0, STL, STL);                                    // 20
    add(0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, FLS, FLS);        // 21 branch aborts stall
    zero(FLS, DEF);                                           // 22
    zero(DEF, DEF);                                           // 23
    hit_a(0, 0, STL, STL);                                    // 24 enters stall, 2 left
    hit_a(0, 1, FRZ, FRZ);                                    // 25 freeze holds counter
    hit_a(0, 1, FRZ, FRZ);                                    // 26
    hit_a(0, 1, FRZ, FRZ);                                    // 27
    hit_a(0, 1, FRZ, FRZ);                                    // 28
    zero(STL, DEF);                                           // 29
    zero(STL, DEF);                                           // 30
    zero(DEF, DEF);                                           // 31
    add(0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, FLS, FLS);        // 32 branch, then reset mid-flush
    perf(13, 4, 8, 4);
    add(1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, DEF, DEF);        // 33
    perf(0, 0, 0, 0);
    zero(DEF, DEF);                                           // 34 back in IDLE, no flush
    perf(0, 0, 0, 0);

    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      rst            = rows[i].rst;
      bt             = rows[i].bt;
      mem_busy       = rows[i].busy;
      id_ex_mem_read = rows[i].mr;
      id_ex_rd       = rows[i].rd;
      if_id_ra       = rows[i].ra;
      if_id_ra_used  = rows[i].rau;
      if_id_rb       = rows[i].rb;
      if_id_rb_used  = rows[i].rbu;
      #2;
      check($sformatf("row%0d_a", i),
            {11'd0, a_pc_en, a_if_id_en, a_flush, a_bubble, a_freeze}, {11'd0, rows[i].ea});
      check($sformatf("row%0d_b", i),
            {11'd0, b_pc_en, b_if_id_en, b_flush, b_bubble, b_freeze}, {11'd0, rows[i].eb});
`ifdef HU_PERF_CNT_EN
      if (rows[i].pchk) begin
        check($sformatf("row%0d_a_stall_cnt", i), a_stall_cnt, 16'(rows[i].psa));
        check($sformatf("row%0d_a_flush_cnt", i), a_flush_cnt, 16'(rows[i].pfa));
        check($sformatf("row%0d_b_stall_cnt", i), b_stall_cnt, 16'(rows[i].psb));
        check($sformatf("row%0d_b_flush_cnt", i), b_flush_cnt, 16'(rows[i].pfb));
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage core; sits between the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards and stalls for a configurable number of cycles (multi-cycle memory).
- Flushes for a configurable number of cycles after a taken branch, and freezes the whole pipeline while memory reports busy.
- Source-operand valid qualifiers remove false stalls on instructions that do not read ra/rb.

Parameters:
- REG_AW, 2, register-address width (2 gives 4 GPRs).
- LOAD_LAT, 1, total stall cycles per load-use hazard; legal range 1..15.
- FLUSH_CYCLES, 1, cycles the front end is flushed per taken branch; legal range 1..15.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_id_ra  in  REG_AW  source A of the instruction in decode.
- if_id_rb  in  REG_AW  source B of the instruction in decode.
- if_id_ra_used  in  1  decode instruction reads ra.
- if_id_rb_used  in  1  decode instruction reads rb.
- id_ex_rd  in  REG_AW  destination of the instruction in EX.
- id_ex_mem_read  in  1  EX instruction is LDD/LDI/POP.
- bt  in  1  branch taken, resolved in EX.
- mem_busy  in  1  data memory not ready; freeze request.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID register enable.
- flush  out  1  clear IF/ID to NOP.
- id_ex_bubble  out  1  load NOP into ID/EX.
- freeze  out  1  hold all pipeline registers, including EX/MEM and MEM/WB.

Behaviour:
- State register: {IDLE, LU_STALL, BR_FLUSH} plus a down-counter cnt of width $clog2(16) = 4.
- Reset (async, rst=1): state=IDLE, cnt=0.
- While rst=1, outputs are forced to pc_en=1, if_id_en=1, flush=0, id_ex_bubble=0, freeze=0.
- Outputs are Mealy (state plus current inputs). Defaults: pc_en=1, if_id_en=1, flush=0, id_ex_bubble=0, freeze=0.
- hit = id_ex_mem_read && ((if_id_ra_used && id_ex_rd==if_id_ra) || (if_id_rb_used && id_ex_rd==if_id_rb)).
- Priority, highest first: mem_busy, bt, hit.
- mem_busy=1, any state: freeze=1, pc_en=0, if_id_en=0, flush=0, id_ex_bubble=0. State and cnt hold; bt and hit are ignored that cycle. EX holds bt stable while frozen.
- IDLE, bt=1:
  - flush=1, id_ex_bubble=1, pc_en=1.
  - If FLUSH_CYCLES>1: go to BR_FLUSH with cnt=FLUSH_CYCLES-1.
- IDLE, hit=1, bt=0:
  - pc_en=0, if_id_en=0, id_ex_bubble=1.
  - If LOAD_LAT>1: go to LU_STALL with cnt=LOAD_LAT-1.
- LU_STALL:
  - Same stall outputs as the IDLE hit case; cnt decrements each cycle; go to IDLE when cnt==1 at the edge.
  - Total stall = LOAD_LAT cycles.
  - hit is not re-evaluated inside LU_STALL.
- LU_STALL with bt=1: abort the stall. Outputs flush=1, id_ex_bubble=1, pc_en=1, if_id_en=1; proceed as IDLE+bt.
- BR_FLUSH:
  - flush=1, id_ex_bubble=1, pc_en=1; cnt decrements; go to IDLE when cnt==1.
  - A new bt in BR_FLUSH reloads cnt=FLUSH_CYCLES-1.
  - hit is ignored, because the decode instruction is being flushed.
- Back-to-back hazards: a hit on the first IDLE cycle after a stall starts a fresh stall.
- With LOAD_LAT=1 and FLUSH_CYCLES=1 the unit is purely single-cycle and never leaves IDLE.

Optional Feature:
- Macro: HU_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[15:0] (+1 per cycle with pc_en=0 && !freeze).
  - Adds flush_cnt[15:0] (+1 per bt event accepted, i.e. bt=1 && !mem_busy).
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package hu_pkg:
  - hu_state_t enum {IDLE=2'd0, LU_STALL=2'd1, BR_FLUSH=2'd2}.
  - HU_CNT_W=4.
  - LOAD_LAT_MAX=15, FLUSH_CYCLES_MAX=15.
- One sub-module, hu_hit_detect: the combinational hit comparator, parametrised by REG_AW and reused by the forwarding unit.

Test Plan:
- LOAD_LAT=3: LDD r1 in EX, ADD r2,r1 decode with ra_used=1 -> pc_en=0, if_id_en=0, id_ex_bubble=1 for exactly 3 cycles, then pc_en=1.
- id_ex_rd=1, if_id_ra=1 but ra_used=0, rb_used=0 -> no stall; outputs stay at default.
- FLUSH_CYCLES=2, bt pulse in IDLE -> flush=1 and id_ex_bubble=1 for 2 cycles while pc_en=1; a second bt in cycle 2 extends the flush by 1 more cycle.
- LOAD_LAT=3, bt=1 in the 2nd LU_STALL cycle -> stall aborts, flush=1 and pc_en=1 in that same cycle, state returns to IDLE.
- mem_busy=1 for 4 cycles during LU_STALL with cnt=2 -> freeze=1 and cnt held at 2; after release, 2 more stall cycles follow.
- rst asserted mid BR_FLUSH -> outputs return to defaults immediately and state=IDLE; with HU_PERF_CNT_EN, stall_cnt=flush_cnt=0.
